// File: rtl/adc_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_fifo
// Description : ADC frame FIFO. Admits one whole frame per handshake only if
//               the whole frame fits, then serialises it into 32-bit words
//               (status, [timestamp], CH0..CH(NUM_CH-1)) and exposes them on
//               a show-ahead pop port with level, watermark IRQ and sticky
//               overrun/underflow flags.
// Options     : define ADC_FIFO_TS_EN to insert the latched frame timestamp
//               as word 1 of every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_fifo #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 24,
    parameter int DEPTH    = 32,
    parameter int LEVEL_W  = $clog2(DEPTH) + 1
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0]   frame_data,
    input  logic [31:0]                  frame_ts,
    input  logic                         pop,
    output logic [31:0]                  rd_data,
    output logic                         rd_valid,
    output logic [LEVEL_W-1:0]           level,
    input  logic [LEVEL_W-1:0]           watermark,
    output logic                         irq_wm,
    input  logic                         flush,
    input  logic [1:0]                   clr_flags,
    output logic                         overrun,
    output logic                         underflow,
    output logic [15:0]                  drop_count
);

    localparam int c_AW = $clog2(DEPTH);
`ifdef ADC_FIFO_TS_EN
    localparam int c_HDR = 2;
`else
    localparam int c_HDR = 1;
`endif
    localparam int c_FRAME_WORDS = NUM_CH + c_HDR;
    localparam int c_IDX_W       = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [31:0]                 r_mem [DEPTH];
    logic [c_AW-1:0]             r_wr_ptr;
    logic [c_AW-1:0]             r_rd_ptr;
    logic [LEVEL_W-1:0]          r_level;
    logic [c_IDX_W-1:0]          r_word_idx;
    logic [NUM_CH*SAMPLE_W-1:0]  r_frame;
    logic [15:0]                 r_seq;
    logic [15:0]                 r_drop_count;
    logic [7:0]                  r_drop_since;
    logic                        r_overrun;
    logic                        r_underflow;

    logic                        w_accept;
    logic                        w_drop;
    logic                        w_push;
    logic [31:0]                 w_wdata;
    logic [31:0]                 w_status;
    logic [31:0]                 w_body;
    logic [c_IDX_W-1:0]          w_ch_sel;
    logic [LEVEL_W-1:0]          w_free;
    logic                        w_has_space;
    logic                        w_pop_ok;
    logic                        w_pop_empty;
    logic [31:0]                 w_ch_word [NUM_CH];

`ifdef ADC_FIFO_TS_EN
    logic [31:0]                 r_ts;
`else
    logic                        w_unused_ts;
    assign w_unused_ts = ^frame_ts;
`endif

    // Sign-extend every latched sample to a full word
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_ch_word[gi] = 32'($signed(r_frame[gi*SAMPLE_W +: SAMPLE_W]));
        end
    endgenerate

    // Space check uses registered level; a same-cycle pop is not credited
    assign w_free      = LEVEL_W'(DEPTH) - r_level;
    assign w_has_space = (w_free >= LEVEL_W'(c_FRAME_WORDS));
    assign w_pop_ok    = pop && (r_level != '0) && !flush;
    assign w_pop_empty = pop && (r_level == '0) && !flush;
    assign w_status    = {r_seq, 4'h0, 4'(NUM_CH), r_drop_since};
    assign w_ch_sel    = r_word_idx - c_IDX_W'(c_HDR);

    // Select the payload word for the current position inside the frame
    always_comb begin
        w_body = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_sel == c_IDX_W'(i)) begin
                w_body = w_ch_word[i];
            end
        end
`ifdef ADC_FIFO_TS_EN
        if (r_word_idx == c_IDX_W'(1)) begin
            w_body = r_ts;
        end
`endif
    end

    // Next-state and write-side control; flush aborts everything
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_push      = 1'b0;
        w_wdata     = '0;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_valid) begin
                        if (w_has_space) begin
                            w_accept    = 1'b1;
                            w_push      = 1'b1;
                            w_wdata     = w_status;
                            w_state_nxt = WRITE;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    w_push  = 1'b1;
                    w_wdata = w_body;
                    if (r_word_idx == c_IDX_W'(c_FRAME_WORDS - 1)) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage and frame latch carry no reset; validity is tracked by level
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
        if (w_accept) begin
            r_frame <= frame_data;
`ifdef ADC_FIFO_TS_EN
            r_ts    <= frame_ts;
`endif
        end
    end

    // Pointers, level, counters and sticky flags
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_word_idx   <= '0;
            r_seq        <= '0;
            r_drop_count <= '0;
            r_drop_since <= '0;
            r_overrun    <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_level <= r_level + LEVEL_W'(w_push) - LEVEL_W'(w_pop_ok);
            end

            if (w_accept) begin
                r_word_idx <= c_IDX_W'(1);
            end else if (r_state == WRITE) begin
                r_word_idx <= r_word_idx + 1'b1;
            end

            if (w_accept) begin
                r_seq        <= r_seq + 1'b1;
                r_drop_since <= '0;
            end else if (w_drop && (r_drop_since != 8'hFF)) begin
                r_drop_since <= r_drop_since + 1'b1;
            end

            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end

            // A set in the same cycle wins over a clear
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_flags[0]) begin
                r_overrun <= 1'b0;
            end

            if (w_pop_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_flags[1]) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign frame_ready = (r_state == IDLE);
    assign rd_valid    = (r_level != '0);
    assign rd_data     = rd_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign level       = r_level;
    assign irq_wm      = (watermark != '0) && (r_level >= watermark);
    assign overrun     = r_overrun;
    assign underflow   = r_underflow;
    assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_frame_fifo
// Description : Scoreboard bench for adc_frame_fifo. A queue-based reference
//               model tracks stored words, frames in flight and flags; a
//               negedge monitor compares DUT outputs and popped words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_frame_fifo;

    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 24;
    localparam int DEPTH    = 16;
    localparam int LEVEL_W  = 5;
`ifdef ADC_FIFO_TS_EN
    localparam int FW = NUM_CH + 2;
`else
    localparam int FW = NUM_CH + 1;
`endif

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        frame_valid;
    logic                        frame_ready;
    logic [NUM_CH*SAMPLE_W-1:0]  frame_data;
    logic [31:0]                 frame_ts;
    logic                        pop;
    logic [31:0]                 rd_data;
    logic                        rd_valid;
    logic [LEVEL_W-1:0]          level;
    logic [LEVEL_W-1:0]          watermark;
    logic                        irq_wm;
    logic                        flush;
    logic [1:0]                  clr_flags;
    logic                        overrun;
    logic                        underflow;
    logic [15:0]                 drop_count;

    adc_frame_fifo #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .LEVEL_W  (LEVEL_W)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_ts    (frame_ts),
        .pop         (pop),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .level       (level),
        .watermark   (watermark),
        .irq_wm      (irq_wm),
        .flush       (flush),
        .clr_flags   (clr_flags),
        .overrun     (overrun),
        .underflow   (underflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];
    int          m_level;
    int          m_seq;
    int          m_ds;
    int          m_drops;
    bit          m_ovr;
    bit          m_unf;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input longint s);
        if (s >= (64'sd1 <<< (SAMPLE_W - 1))) return 32'(s - (64'sd1 <<< SAMPLE_W));
        return 32'(s);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        m_level = 0;
        m_seq   = 0;
        m_ds    = 0;
        m_drops = 0;
        m_ovr   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Reference behaviour for one clock edge, using the inputs sampled there
    task automatic model_step();
        bit drop = 1'b0;
        bit unf  = 1'b0;
        int push = 0;
        int popv;
        if (rst) begin
            model_reset();
            return;
        end
        if (flush) begin
            exp_q.delete();
            pend_q.delete();
            m_level = 0;
        end else begin
            popv = (pop && m_level > 0) ? 1 : 0;
            if (pend_q.size() > 0) begin
                exp_q.push_back(pend_q.pop_front());
                push = 1;
            end else if (frame_valid) begin
                if (DEPTH - m_level >= FW) begin
                    exp_q.push_back({m_seq[15:0], 4'h0, 4'(NUM_CH), m_ds[7:0]});
`ifdef ADC_FIFO_TS_EN
                    pend_q.push_back(frame_ts);
`endif
                    for (int i = 0; i < NUM_CH; i++)
                        pend_q.push_back(sext(longint'(frame_data[i*SAMPLE_W +: SAMPLE_W])));
                    m_seq = (m_seq + 1) % 65536;
                    m_ds  = 0;
                    push  = 1;
                end else begin
                    drop = 1'b1;
                    if (m_drops < 65535) m_drops++;
                    if (m_ds < 255) m_ds++;
                end
            end
            if (pop && m_level == 0) unf = 1'b1;
            m_level = m_level + push - popv;
        end
        m_ovr = drop ? 1'b1 : (clr_flags[0] ? 1'b0 : m_ovr);
        m_unf = unf  ? 1'b1 : (clr_flags[1] ? 1'b0 : m_unf);
    endtask

    // Monitor: compare status outputs and consume a scoreboard word per pop
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("level", level, m_level);
            chk("rd_valid", rd_valid, m_level != 0);
            chk("frame_ready", frame_ready, pend_q.size() == 0);
            chk("irq_wm", irq_wm, (watermark != 0) && (m_level >= watermark));
            chk("overrun", overrun, m_ovr);
            chk("underflow", underflow, m_unf);
            chk("drop_count", drop_count, m_drops);
            if (m_level == 0) begin
                chk("rd_data_empty", rd_data, 0);
            end else if (pop && !flush) begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pop_n(input int n);
        pop = 1'b1;
        repeat (n) tick();
        pop = 1'b0;
    endtask

    task automatic send_frame(input logic [NUM_CH*SAMPLE_W-1:0] d, input logic [31:0] ts);
        for (int k = 0; k < 64 && pend_q.size() != 0; k++) tick();
        frame_valid = 1'b1;
        frame_data  = d;
        frame_ts    = ts;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
    endtask

    function automatic logic [NUM_CH*SAMPLE_W-1:0] rand_frame();
        logic [NUM_CH*SAMPLE_W-1:0] d;
        for (int i = 0; i < NUM_CH; i++) d[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
        return d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH*SAMPLE_W-1:0] d;
        rst = 1'b1; frame_valid = 1'b0; frame_data = '0; frame_ts = '0;
        pop = 1'b0; watermark = '0; flush = 1'b0; clr_flags = '0;
        model_reset();
        idle(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Incrementing channels, timestamp, watermark at one full frame
        watermark = LEVEL_W'(FW);
        for (int i = 0; i < NUM_CH; i++) d[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(32'h100 + i);
        send_frame(d, 32'hDEAD_BEEF);
        idle(FW + 1);
        pop_n(FW);
        idle(2);

        // Negative sample exercises sign extension
        d = rand_frame();
        d[SAMPLE_W-1:0] = 24'h800001;
        send_frame(d, 32'h1234_5678);
        idle(FW);
        pop_n(FW);

        // Reset in the middle of a frame, then drop scenario from fresh state
        send_frame(rand_frame(), $urandom);
        idle(3);
        do_reset();
        send_frame(rand_frame(), $urandom);
        send_frame(rand_frame(), $urandom);
        idle(2);
        pop_n(FW);
        send_frame(rand_frame(), $urandom);
        idle(FW);
        pop_n(FW);

        // Empty pops, with an underflow clear colliding with a new set
        pop = 1'b1;
        tick();
        clr_flags = 2'b10;
        tick();
        pop = 1'b0;
        clr_flags = 2'b00;
        tick();
        clr_flags = 2'b11;
        tick();
        clr_flags = 2'b00;
        idle(1);

        // Flush in the 4th cycle of a frame write, then a complete frame
        send_frame(rand_frame(), $urandom);
        idle(2);
        flush = 1'b1;
        frame_valid = 1'b1;
        pop = 1'b1;
        tick();
        flush = 1'b0;
        frame_valid = 1'b0;
        pop = 1'b0;
        send_frame(rand_frame(), $urandom);
        idle(FW);
        pop_n(FW);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            frame_valid = ($urandom_range(0, 2) == 0);
            frame_data  = rand_frame();
            frame_ts    = $urandom;
            pop         = ($urandom_range(0, 1) == 0);
            flush       = ($urandom_range(0, 63) == 0);
            clr_flags   = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 99) == 0) watermark = LEVEL_W'($urandom_range(0, DEPTH));
            tick();
        end
        frame_valid = 1'b0; pop = 1'b0; flush = 1'b0; clr_flags = '0;
        idle(FW + 2);
        pop_n(DEPTH + 2);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
